// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD countdown timer driven by rising edges of a divided clock.
// Optional 7-segment decode output enabled by defining BCD_TIMER_SEG7_EN.
module bcd_countdown_timer #(
  parameter int DIGITS             = 4,
  parameter int ZERO_START_EXPIRES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slow_clk_in,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  running,
  output logic                  expired,
  output logic                  expired_pulse
`ifdef BCD_TIMER_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg_n
`endif
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           slow_q;
  logic           pulse_q, pulse_d;
  logic           running_q, running_d;
  logic           expired_q, expired_d;

  logic [W-1:0]   dec_value;
  logic [W-1:0]   clamp_value;
  logic [DIGITS-1:0] borrow;
  logic           tick;
  logic           count_zero;
  logic           dec_zero;
  logic           do_dec;

  assign tick       = slow_clk_in & ~slow_q;
  assign count_zero = (count_q == '0);
  assign dec_zero   = (dec_value == '0);
  assign borrow[0]  = 1'b1;

  // Ripple-borrow BCD decrement plus per-digit clamp of the preset.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] cur_digit;
    logic [3:0] ld_digit;
    assign cur_digit = count_q[4*gi +: 4];
    assign ld_digit  = load_value[4*gi +: 4];
    assign dec_value[4*gi +: 4] = borrow[gi]
                                  ? ((cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1)
                                  : cur_digit;
    assign clamp_value[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
    if (gi > 0) begin : g_borrow
      assign borrow[gi] = borrow[gi-1] & (count_q[4*(gi-1) +: 4] == 4'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
    do_dec  = 1'b0;
    if (load) begin
      count_d = clamp_value;
      state_d = S_IDLE;
    end else if (start) begin
      if (state_q == S_IDLE || state_q == S_PAUSED) begin
        if (!count_zero) begin
          state_d = S_RUN;
        end else if (ZERO_START_EXPIRES != 0) begin
          state_d = S_DONE;
          pulse_d = 1'b1;
        end
      end else if (state_q == S_RUN) begin
        // start has no effect while running, so the tick still counts
        do_dec = tick;
      end
    end else if (pause) begin
      if (state_q == S_RUN) begin
        state_d = S_PAUSED;
      end
    end else if (state_q == S_RUN) begin
      do_dec = tick;
    end

    if (do_dec) begin
      count_d = dec_value;
      if (dec_zero) begin
        state_d = S_DONE;
        pulse_d = 1'b1;
      end
    end

    running_d = (state_d == S_RUN);
    expired_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      slow_q    <= 1'b0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      slow_q    <= slow_clk_in;
      pulse_q   <= pulse_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign count_bcd     = count_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;

`ifdef BCD_TIMER_SEG7_EN
  logic [7*DIGITS-1:0] seg_q, seg_d;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    assign seg_d[7*gi +: 7] = seg7_decode(count_q[4*gi +: 4]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= '1;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_n = seg_q;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized and directed checks of bcd_countdown_timer against an integer-count model.
// Segment checks are included when BCD_TIMER_SEG7_EN is defined.
module tb_bcd_countdown_timer;

  localparam int ST_IDLE   = 0;
  localparam int ST_RUN    = 1;
  localparam int ST_PAUSED = 2;
  localparam int ST_DONE   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        slow_clk_in = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] count_bcd;
  logic        running, expired, expired_pulse;
  logic [15:0] nz_count;
  logic        nz_running, nz_expired, nz_pulse;
`ifdef BCD_TIMER_SEG7_EN
  logic [27:0] seg_n;
  logic [27:0] nz_seg;
`endif

  bcd_countdown_timer #(.DIGITS(4), .ZERO_START_EXPIRES(1)) dut (
    .clk(clk), .reset(reset), .slow_clk_in(slow_clk_in),
    .load(load), .load_value(load_value), .start(start), .pause(pause),
    .count_bcd(count_bcd), .running(running), .expired(expired),
    .expired_pulse(expired_pulse)
`ifdef BCD_TIMER_SEG7_EN
    , .seg_n(seg_n)
`endif
  );

  bcd_countdown_timer #(.DIGITS(4), .ZERO_START_EXPIRES(0)) dut_nz (
    .clk(clk), .reset(reset), .slow_clk_in(slow_clk_in),
    .load(load), .load_value(load_value), .start(start), .pause(pause),
    .count_bcd(nz_count), .running(nz_running), .expired(nz_expired),
    .expired_pulse(nz_pulse)
`ifdef BCD_TIMER_SEG7_EN
    , .seg_n(nz_seg)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int          m_cnt;
  int          m_st;
  bit          m_pulse;
  bit          m_prev;
  logic [27:0] m_seg;

  localparam logic [6:0] SEG_ON [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(input logic [15:0] b);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [27:0] seg_of(input int v);
    logic [27:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[7*i +: 7] = ~SEG_ON[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_st = ST_IDLE; m_pulse = 0; m_prev = 0; m_seg = '1;
  endtask

  task automatic model_step(input bit l, input logic [15:0] lv, input bit s, input bit p, input bit sc);
    bit tk;
    bit dec;
    tk = sc && !m_prev;
    m_prev = sc;
    m_seg = seg_of(m_cnt);
    m_pulse = 0;
    dec = 0;
    if (l) begin
      m_cnt = from_bcd_clamped(lv);
      m_st = ST_IDLE;
    end else if (s) begin
      if (m_st == ST_IDLE || m_st == ST_PAUSED) begin
        if (m_cnt != 0) m_st = ST_RUN;
        else begin m_st = ST_DONE; m_pulse = 1; end
      end else if (m_st == ST_RUN) dec = tk;
    end else if (p) begin
      if (m_st == ST_RUN) m_st = ST_PAUSED;
    end else if (m_st == ST_RUN) dec = tk;
    if (dec) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_st = ST_DONE; m_pulse = 1; end
    end
  endtask

  task automatic check_all();
    check("count", 32'(count_bcd), 32'(to_bcd(m_cnt)));
    check("running", 32'(running), 32'(m_st == ST_RUN));
    check("expired", 32'(expired), 32'(m_st == ST_DONE));
    check("pulse", 32'(expired_pulse), 32'(m_pulse));
`ifdef BCD_TIMER_SEG7_EN
    check("seg_n", 32'(seg_n), 32'(m_seg));
`endif
  endtask

  task automatic cycle(input bit l, input logic [15:0] lv, input bit s, input bit p, input bit sc);
    load = l; load_value = lv; start = s; pause = p; slow_clk_in = sc;
    model_step(l, lv, s, p, sc);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      cycle(0, 16'h0, 0, 0, 1);
      cycle(0, 16'h0, 0, 0, 0);
    end
  endtask

  initial begin
    int r;
    bit l, s, p, sc;
    logic [15:0] lv;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    $display("reset state checked");

    cycle(1, 16'h0012, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    tick_n(12);
    check("t12_expired", 32'(expired), 32'd1);
    check("t12_running", 32'(running), 32'd0);
    $display("countdown 0012 -> 0000 done");

    cycle(1, 16'h1000, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    tick_n(1);
    check("borrow_1000", 32'(count_bcd), 32'h0999);
    $display("borrow 1000 -> 0999 done");

    cycle(1, 16'h0050, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 0, 1, 0);
    tick_n(3);
    check("pause_hold", 32'(count_bcd), 32'h0050);
    check("pause_running", 32'(running), 32'd0);
    cycle(0, 16'h0, 1, 0, 0);
    tick_n(1);
    check("resume_dec", 32'(count_bcd), 32'h0049);
    $display("pause/resume done");

    cycle(1, 16'h0123, 1, 0, 1);
    check("load_start_tick", 32'(count_bcd), 32'h0123);
    check("load_start_idle", 32'(running), 32'd0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 0, 1, 0);
    cycle(0, 16'h0, 1, 0, 1);
    check("start_tick_paused", 32'(count_bcd), 32'h0123);
    cycle(0, 16'h0, 0, 0, 0);
    $display("collisions done");

    cycle(1, 16'h00C5, 0, 0, 0);
    check("clamp", 32'(count_bcd), 32'h0095);
    $display("clamp done");

    cycle(1, 16'h0000, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    check("zero_start_pulse", 32'(expired_pulse), 32'd1);
    check("nz_flags", 32'({nz_running, nz_expired, nz_pulse}), 32'd0);
    check("nz_count", 32'(nz_count), 32'd0);
    cycle(0, 16'h0, 0, 0, 0);
    $display("zero start done");

    cycle(1, 16'h0030, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    tick_n(4);
    load = 0; start = 0; pause = 0; slow_clk_in = 0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    $display("mid-count reset done");

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      l  = (r < 3);
      s  = (r >= 3 && r < 9);
      p  = (r >= 9 && r < 12);
      if ($urandom_range(0, 9) == 0) lv = 16'($urandom);
      else lv = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      sc = ($urandom_range(0, 2) == 0) ? ~slow_clk_in : slow_clk_in;
      cycle(l, lv, s, p, sc);
    end
    $display("random phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD countdown timer that consumes the divided clock output of the frequency divider (typically 1 Hz) as its time base.
- Detects rising edges of the slow clock in the fast clk domain, producing a one-cycle tick.
- The tick decrements a loadable BCD count under start/pause/load control.
- Drives the display path and flags expiry to the system controller.

Parameters:
- DIGITS, 4: number of BCD digits. Legal range 1..8.
- ZERO_START_EXPIRES, 1: a start command issued with count == 0. If 1, the timer goes directly to DONE and pulses expired_pulse. If 0, the command is ignored.

Ports:
- clk  input  1  system clock; the same clock that feeds the frequency divider.
- reset  input  1  asynchronous, active-low.
- slow_clk_in  input  1  divided clock from the frequency divider. It is a register output in the clk domain, so no synchroniser is needed.
- load  input  1  one-cycle command: load load_value into the count.
- load_value  input  4*DIGITS  BCD preset. Digit 0 is in bits [3:0].
- start  input  1  one-cycle command: begin or resume counting.
- pause  input  1  one-cycle command: suspend counting.
- count_bcd  output  4*DIGITS  current BCD count.
- running  output  1  high while in state RUN.
- expired  output  1  level; high while in state DONE.
- expired_pulse  output  1  single-cycle pulse on entry to DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, count_bcd=0, slow_d=0, running=0, expired=0, expired_pulse=0.
- Tick generation:
  - tick = slow_clk_in & ~slow_d; slow_d <= slow_clk_in every clk.
  - Exactly one tick per slow_clk_in rising edge.
  - tick is high during the first clk cycle in which slow_clk_in is sampled high.
  - Falling edges are ignored.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
- Command priority: load > start > pause. Lower-priority commands in the same cycle are discarded.
- load (any state):
  - count <= load_value, with each digit > 9 clamped to 9.
  - Next state IDLE; any pending tick in that cycle is discarded.
  - Clears expired.
- start:
  - From IDLE or PAUSED with count != 0: go to RUN. A tick in the same cycle is not counted.
  - From IDLE or PAUSED with count == 0: behaviour set by ZERO_START_EXPIRES.
  - Ignored in RUN and DONE.
- pause:
  - RUN -> PAUSED; the count holds.
  - A tick in the same cycle is not counted.
  - Ignored in other states.
- Decrement (RUN with tick):
  - BCD decrement with borrow: a digit at 0 becomes 9 and borrows from the next digit.
  - Example: 1000 -> 0999.
  - Result is computed combinationally and registered at the tick edge. Latency: count changes 1 clk after slow_clk_in rises.
- Expiry:
  - When the decremented result is 0, count becomes 0 and state becomes DONE on the same clk edge.
  - expired and expired_pulse both go high on that edge; expired_pulse drops the following cycle.
- DONE: count holds at 0. Only load leaves DONE. Ticks are ignored.
- Ticks in IDLE or PAUSED: ignored, count holds.
- running = (state == RUN); expired = (state == DONE).
- Reset mid-count: immediate return to reset values. No pulse is emitted.

Optional Feature:
- Macro: BCD_TIMER_SEG7_EN.
- When defined:
  - Adds output seg_n (7*DIGITS bits): active-low segments {g,f,e,d,c,b,a} per digit, with digit 0 in bits [6:0].
  - Registered decode of count_bcd, valid 1 clk after count_bcd changes.
  - Reset value is all ones (blank).
  - Digits 0-9 use the standard patterns.
- When undefined: the port and decode logic are absent, and all other behaviour is identical.

Test Plan:
- Reset release, then load 0012, start, 12 slow_clk_in rising edges.
  - count goes 0012 -> 0011 ... 0001 -> 0000.
  - expired_pulse is high exactly 1 cycle, coincident with count 0000.
  - expired stays 1 and running goes to 0.
- Load 1000, start, 1 tick -> count 0999. Borrow across three digits is verified.
- RUN at 0050, pause, 3 ticks -> count stays 0050 and running=0. Then start plus 1 tick -> 0049.
- Same-cycle collisions:
  - load=1 and start=1 with tick -> count=load_value, state IDLE.
  - start and tick together in PAUSED -> count is unchanged that cycle.
- Load value with digit 0xC (load_value=0x00C5) -> count 0095.
- Start at count 0000 -> with ZERO_START_EXPIRES=1, DONE and pulse; with 0, stays IDLE.
- Assert reset in the middle of a countdown -> all outputs return to their reset values within that cycle, with no expired_pulse.
